// File: rtl/clk_div_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_multi                                                |
// | Description : Bank of independent programmable dividers, each producing a  |
// |               square wave or a one-cycle strobe from a shared clock.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module clk_div_multi #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS*WIDTH-1:0] final_val,
    input  logic [CHANNELS-1:0]       mode,
    output logic [CHANNELS-1:0]       count_out,
    output logic [CHANNELS-1:0]       busy
);

    localparam logic             c_idle = 1'b0;
    localparam logic             c_run  = 1'b1;
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             r_state;
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_final_q;
        logic             r_mode_q;
        logic             r_out;
        logic             r_busy;
        logic [WIDTH-1:0] w_final;
        logic             w_final_nz;

        assign w_final    = final_val[i*WIDTH +: WIDTH];
        assign w_final_nz = (w_final != c_zero);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state   <= c_idle;
                r_cnt     <= c_zero;
                r_final_q <= c_zero;
                r_mode_q  <= 1'b0;
                r_out     <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    c_idle: begin
                        r_cnt <= c_zero;
                        r_out <= 1'b0;
                        if (start[i] && w_final_nz) begin
                            r_state   <= c_run;
                            r_final_q <= w_final;
                            r_mode_q  <= mode[i];
                            r_busy    <= 1'b1;
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end
                    c_run: begin
                        if (!start[i]) begin
                            r_state <= c_idle;
                            r_cnt   <= c_zero;
                            r_out   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (r_cnt == r_final_q) begin
                            r_cnt <= c_zero;
                            r_out <= r_mode_q ? 1'b1 : ~r_out;
                            // A zero terminal count is not loadable, keep the running setup.
                            if (w_final_nz) begin
                                r_final_q <= w_final;
                                r_mode_q  <= mode[i];
                            end
                        end else begin
                            r_cnt <= r_cnt + c_one;
                            if (r_mode_q) begin
                                r_out <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_idle;
                        r_cnt   <= c_zero;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end

        assign count_out[i] = r_out;
        assign busy[i]      = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clk_div_multi                                             |
// | Description : Scoreboard bench for clk_div_multi with a schedule-based     |
// |               reference model of every channel.                            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_clk_div_multi;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int NCYC     = 700;

    logic                      clk;
    logic                      reset;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS*WIDTH-1:0] final_val;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS-1:0]       count_out;
    logic [CHANNELS-1:0]       busy;

    int errors = 0;
    int checks = 0;

    logic [2*CHANNELS-1:0] exp_q[$];
    bit driver_done = 0;

    // Reference model: absolute edge index of each channel's next terminal.
    bit m_run [CHANNELS];
    bit m_mode[CHANNELS];
    bit m_out [CHANNELS];
    int m_fin [CHANNELS];
    int m_next[CHANNELS];

    clk_div_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .final_val (final_val),
        .mode      (mode),
        .count_out (count_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        for (int i = 0; i < CHANNELS; i++) begin
            m_run[i] = 0; m_mode[i] = 0; m_out[i] = 0; m_fin[i] = 0; m_next[i] = 0;
        end
    endtask

    task automatic model_edge(input int e);
        logic [2*CHANNELS-1:0] v;
        int f;
        for (int i = 0; i < CHANNELS; i++) begin
            f = int'(final_val[i*WIDTH +: WIDTH]);
            if (reset) begin
                m_run[i] = 0; m_mode[i] = 0; m_out[i] = 0; m_fin[i] = 0;
            end else if (!m_run[i]) begin
                m_out[i] = 0;
                if (start[i] && f != 0) begin
                    m_run[i]  = 1;
                    m_fin[i]  = f;
                    m_mode[i] = mode[i];
                    m_next[i] = e + f + 1;
                end
            end else if (!start[i]) begin
                m_run[i] = 0;
                m_out[i] = 0;
            end else if (e == m_next[i]) begin
                m_out[i] = m_mode[i] ? 1'b1 : !m_out[i];
                if (f != 0) begin
                    m_fin[i]  = f;
                    m_mode[i] = mode[i];
                end
                m_next[i] = e + m_fin[i] + 1;
            end else if (m_mode[i]) begin
                m_out[i] = 0;
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            v[i]            = m_out[i];
            v[CHANNELS + i] = m_run[i];
        end
        exp_q.push_back(v);
    endtask

    task automatic set_final(input int ch, input int val);
        final_val[ch*WIDTH +: WIDTH] = WIDTH'(val);
    endtask

    task automatic check_idle_now(input string name);
        checks++;
        if (count_out !== '0 || busy !== '0) begin
            errors++;
            $display("FAIL %s count_out=%b busy=%b required count_out=0000 busy=0000",
                     name, count_out, busy);
        end
    endtask

    // Monitor: one expected vector per clock edge once the driver starts pushing.
    initial begin
        logic [2*CHANNELS-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (count_out !== exp[CHANNELS-1:0] || busy !== exp[2*CHANNELS-1:CHANNELS]) begin
                    errors++;
                    $display("FAIL outputs t=%0t count_out=%b busy=%b required count_out=%b busy=%b",
                             $time, count_out, busy, exp[CHANNELS-1:0], exp[2*CHANNELS-1:CHANNELS]);
                end
            end
        end
    end

    // Driver: sets inputs at the falling edge and predicts the next rising edge.
    initial begin
        reset     = 1'b1;
        start     = '0;
        mode      = '0;
        final_val = '0;
        model_clear();
        #1;
        check_idle_now("reset_state");
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                reset = 1'b1;
                start = '1;
                set_final(0, 3); set_final(1, 4); set_final(2, 5); set_final(3, 15);
            end else if (cyc < 120) begin
                reset = 1'b0;
                mode  = 4'b0010;
                start = 4'b1111;
                set_final(0, (cyc < 35) ? 3 : (cyc < 60) ? 1 : 0);
                set_final(1, (cyc < 45) ? 4 : 0);
                set_final(3, 15);
                if (cyc >= 20 && cyc < 23) start[2] = 1'b0;
                if (cyc >= 23 && cyc < 27) set_final(2, 0);
                else if (cyc >= 27)        set_final(2, 2);
                if (cyc == 90) begin
                    set_final(0, 6); set_final(1, 9);
                end
                if (cyc == 75) begin
                    #2 reset = 1'b1;
                    #1 check_idle_now("async_reset");
                    model_clear();
                    #1 reset = 1'b0;
                end
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if ($urandom_range(0, 19) == 0) start[i] = ~start[i];
                    if ($urandom_range(0, 7) == 0)  set_final(i, $urandom_range(0, 15));
                    if ($urandom_range(0, 39) == 0) mode[i] = ~mode[i];
                end
            end
            model_edge(cyc);
        end
        @(negedge clk);
        driver_done = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
